contador_pulsadores: RTL and testbench

CONTADOR_PULSADORES -- requirements
Module: contador_pulsadores

---
 rtl/contador_pulsadores.sv | 122 ++++++++++++
 tb/tb_contador_pulsadores.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_pulsadores.sv
// contador_pulsadores: 4-bit up/down/load counter driven by three push-buttons.
//
// Each active-low key goes through a two-flop synchronizer and an independent
// debouncer (stable level + run counter). A released->pressed transition of the
// debounced level is a press event; releases and held keys do nothing.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive cycles a new key level must persist (>= 2)
//   WRAP            : 1 = wrap at 0/15, 0 = saturate at 0/15
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   key_up_n   : increment button, active-low, asynchronous
//   key_down_n : decrement button, active-low, asynchronous
//   key_load_n : load button, active-low, asynchronous
//   switches   : value loaded on an accepted load press
//   value      : registered count 0..15
//   update     : one-cycle strobe, high on every write of value
module contador_pulsadores #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned WRAP            = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       key_load_n,
  input  logic [3:0] switches,
  output logic [3:0] value,
  output logic       update
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

  // Bit 0 = up, bit 1 = down, bit 2 = load.
  logic [2:0] keys_n;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] accept;
  logic [2:0] press;

  assign keys_n = {key_load_n, key_down_n, key_up_n};

  // Released level is 1, so the synchronizer resets to all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= keys_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_deb
    logic [CW-1:0] cnt_q;
    logic          stable_q;

    // The counter holds how many consecutive edges sync has differed from the
    // stable level; the edge that sees it at CntLast commits the new level.
    assign accept[k] = (sync2_q[k] != stable_q) && (cnt_q == CntLast);
    assign press[k]  = accept[k] && !sync2_q[k];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        stable_q <= 1'b1;
      end else if (sync2_q[k] == stable_q) begin
        cnt_q <= '0;
      end else if (accept[k]) begin
        cnt_q    <= '0;
        stable_q <= sync2_q[k];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  logic [3:0] value_q, value_d;
  logic       update_q, update_d;

  always_comb begin
    value_d  = value_q;
    update_d = 1'b0;
    if (press[2]) begin
      // Load always writes, even when the value is unchanged.
      value_d  = switches;
      update_d = 1'b1;
    end else if (press[0] && !press[1]) begin
      if (value_q != 4'hF) begin
        value_d  = value_q + 4'd1;
        update_d = 1'b1;
      end else if (WRAP != 0) begin
        value_d  = 4'h0;
        update_d = 1'b1;
      end
    end else if (press[1] && !press[0]) begin
      if (value_q != 4'h0) begin
        value_d  = value_q - 4'd1;
        update_d = 1'b1;
      end else if (WRAP != 0) begin
        value_d  = 4'hF;
        update_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q  <= 4'h0;
      update_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      update_q <= update_d;
    end
  end

  assign value  = value_q;
  assign update = update_q;

endmodule

// File: tb/tb_contador_pulsadores.sv
// Bench for contador_pulsadores with DEBOUNCE_CYCLES=4: one wrapping and one
// saturating instance share the same key stimulus.
module tb_contador_pulsadores;
  localparam int unsigned D = 4;
  localparam int H = D + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_up_n = 1'b1;
  logic       key_down_n = 1'b1;
  logic       key_load_n = 1'b1;
  logic [3:0] switches = 4'd0;
  logic [3:0] value_w, value_s;
  logic       update_w, update_s;
  logic [9:0] obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  contador_pulsadores #(.DEBOUNCE_CYCLES(D), .WRAP(1)) dut_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_up_n   (key_up_n),
    .key_down_n (key_down_n),
    .key_load_n (key_load_n),
    .switches   (switches),
    .value      (value_w),
    .update     (update_w)
  );

  contador_pulsadores #(.DEBOUNCE_CYCLES(D), .WRAP(0)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_up_n   (key_up_n),
    .key_down_n (key_down_n),
    .key_load_n (key_load_n),
    .switches   (switches),
    .value      (value_s),
    .update     (update_s)
  );

  assign obs = {value_w, update_w, value_s, update_s};

  // Reference model: a key level is accepted once the last D raw samples, seen
  // two edges late through the synchronizer, all differ from the accepted level.
  bit hist [3][H];
  bit stab [3];
  int exp_w, exp_s;
  bit expu_w, expu_s;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < H; i++) hist[k][i] = 1'b1;
      stab[k] = 1'b1;
    end
    exp_w = 0; exp_s = 0; expu_w = 1'b0; expu_s = 1'b0;
  endfunction

  function automatic void apply(inout int v, output bit u, input bit wrap,
                                input bit pu, input bit pd, input bit pl, input int sw);
    int nv;
    nv = v;
    if (pl) nv = sw;
    else if (pu && !pd) nv = (v < 15) ? v + 1 : (wrap ? 0 : 15);
    else if (pd && !pu) nv = (v > 0) ? v - 1 : (wrap ? 15 : 0);
    u = pl || (nv != v);
    v = nv;
  endfunction

  function automatic void model_edge();
    bit raw [3];
    bit pr [3];
    bit all_diff;
    raw[0] = key_up_n; raw[1] = key_down_n; raw[2] = key_load_n;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < H - 1; i++) hist[k][i] = hist[k][i+1];
      hist[k][H-1] = raw[k];
      all_diff = 1'b1;
      for (int i = 0; i < int'(D); i++) if (hist[k][i] == stab[k]) all_diff = 1'b0;
      pr[k] = 1'b0;
      if (all_diff) begin
        stab[k] = ~stab[k];
        pr[k] = (stab[k] == 1'b0);
      end
    end
    apply(exp_w, expu_w, 1'b1, pr[0], pr[1], pr[2], int'(switches));
    apply(exp_s, expu_s, 1'b0, pr[0], pr[1], pr[2], int'(switches));
  endfunction

  function automatic logic [9:0] exp_vec();
    return {exp_w[3:0], expu_w, exp_s[3:0], expu_s};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== 10'h0) begin
      failures++; $display("FAIL reset_initial: got %h want %h", obs, 10'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    switches = 4'd7; key_load_n = 1'b0; hold(6);
    key_load_n = 1'b1; hold(6);
    checks++;
    if (value_w !== 4'd7) begin
      failures++; $display("FAIL reset_preload: got %0d want 7", value_w);
    end
    #2 rst_n = 1'b0;
    #1 model_reset();
    checks++;
    if (obs !== 10'h0) begin
      failures++; $display("FAIL reset_async: got %h want %h", obs, 10'h0);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    int lat = 0;
    int ups = 0;
    key_up_n = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL clean_press_model: got %h want %h", obs, exp_vec());
      end
      if (update_w) ups++;
      if (lat == 0 && value_w !== 4'd0) lat = e;
    end
    key_up_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL clean_release_model: got %h want %h", obs, exp_vec());
      end
      if (update_w) ups++;
    end
    checks++;
    if (lat !== 6) begin
      failures++; $display("FAIL clean_press_latency: got edge %0d want edge 6", lat);
    end
    checks++;
    if (ups !== 1) begin
      failures++; $display("FAIL clean_press_pulses: got %0d want 1", ups);
    end
    checks++;
    if (value_w !== 4'd1) begin
      failures++; $display("FAIL clean_press_value: got %0d want 1", value_w);
    end
  endtask

  task automatic test_glitch();
    switches = 4'd5; key_load_n = 1'b0; hold(6);
    key_load_n = 1'b1; hold(6);
    key_down_n = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c == 3) key_down_n = 1'b1;
      step();
      checks++;
      if (obs !== exp_vec() || value_w !== 4'd5 || update_w !== 1'b0) begin
        failures++;
        $display("FAIL glitch: got %h want %h (value 5, no update)", obs, exp_vec());
      end
    end
  endtask

  task automatic test_boundaries();
    int pw;
    int ps;
    for (int pass = 0; pass < 2; pass++) begin
      pw = 0; ps = 0;
      switches = (pass == 0) ? 4'd15 : 4'd0;
      key_load_n = 1'b0; hold(6);
      key_load_n = 1'b1; hold(6);
      if (pass == 0) key_up_n = 1'b0; else key_down_n = 1'b0;
      for (int c = 0; c < 12; c++) begin
        if (c == 6) begin key_up_n = 1'b1; key_down_n = 1'b1; end
        step();
        checks++;
        if (obs !== exp_vec()) begin
          failures++; $display("FAIL boundary_model: got %h want %h", obs, exp_vec());
        end
        if (update_w) pw++;
        if (update_s) ps++;
      end
      checks++;
      if (value_w !== ((pass == 0) ? 4'd0 : 4'd15) || pw !== 1) begin
        failures++;
        $display("FAIL boundary_wrap: got value %0d pulses %0d want %0d pulses 1",
                 value_w, pw, (pass == 0) ? 0 : 15);
      end
      checks++;
      if (value_s !== ((pass == 0) ? 4'd15 : 4'd0) || ps !== 0) begin
        failures++;
        $display("FAIL boundary_sat: got value %0d pulses %0d want %0d pulses 0",
                 value_s, ps, (pass == 0) ? 15 : 0);
      end
    end
  endtask

  task automatic test_load();
    int ups;
    for (int rep = 0; rep < 2; rep++) begin
      ups = 0;
      switches = 4'd9;
      key_load_n = 1'b0;
      for (int c = 0; c < 12; c++) begin
        if (c == 6) key_load_n = 1'b1;
        step();
        checks++;
        if (obs !== exp_vec()) begin
          failures++; $display("FAIL load_model: got %h want %h", obs, exp_vec());
        end
        if (update_w) ups++;
      end
      checks++;
      if (value_w !== 4'd9 || ups !== 1) begin
        failures++; $display("FAIL load_nine: got value %0d pulses %0d want 9 pulses 1",
                             value_w, ups);
      end
    end
    checks++;
    if ((int'(value_w) / 10) !== 0 || (int'(value_w) % 10) !== 9) begin
      failures++; $display("FAIL load_bcd: got %0d%0d want 09",
                           int'(value_w) / 10, int'(value_w) % 10);
    end
  endtask

  task automatic test_simultaneous();
    int lat;
    key_up_n = 1'b0; key_down_n = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) begin key_up_n = 1'b1; key_down_n = 1'b1; end
      step();
      checks++;
      if (obs !== exp_vec() || value_w !== 4'd9 || update_w !== 1'b0) begin
        failures++; $display("FAIL up_down_same: got %h want %h", obs, exp_vec());
      end
    end
    switches = 4'd12; key_up_n = 1'b0; key_load_n = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) begin key_up_n = 1'b1; key_load_n = 1'b1; end
      step();
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL load_over_up: got %h want %h", obs, exp_vec());
      end
    end
    checks++;
    if (value_w !== 4'd12 || value_s !== 4'd12) begin
      failures++; $display("FAIL load_over_up_value: got %0d/%0d want 12", value_w, value_s);
    end
    // Reset mid-debounce with the key released before reset ends.
    key_up_n = 1'b0; hold(3);
    #2 rst_n = 1'b0;
    #1 model_reset();
    checks++;
    if (obs !== 10'h0) begin
      failures++; $display("FAIL reset_debounce: got %h want %h", obs, 10'h0);
    end
    key_up_n = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (obs !== exp_vec() || value_w !== 4'd0 || update_w !== 1'b0) begin
        failures++; $display("FAIL reset_discard: got %h want %h", obs, exp_vec());
      end
    end
    // Reset mid-debounce with the key still held: needs a full requalification.
    key_up_n = 1'b0; hold(3);
    #2 rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk) rst_n = 1'b1;
    lat = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL reset_held_model: got %h want %h", obs, exp_vec());
      end
      if (lat == 0 && value_w !== 4'd0) lat = e;
    end
    key_up_n = 1'b1; hold(6);
    checks++;
    if (lat !== 6 || value_w !== 4'd1) begin
      failures++; $display("FAIL reset_held_requalify: got edge %0d value %0d want edge 6 value 1",
                           lat, value_w);
    end
  endtask

  task automatic test_random();
    int len;
    for (int seg = 0; seg < 120; seg++) begin
      key_up_n   = ($urandom_range(0, 2) != 0);
      key_down_n = ($urandom_range(0, 2) != 0);
      key_load_n = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) switches = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        step();
        checks++;
        if (obs !== exp_vec()) begin
          failures++; $display("FAIL random seg %0d: got %h want %h", seg, obs, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_boundaries();
    test_load();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
